uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
//==============================================================================
// Module   : uart_rx
// Brief    : 16x-oversampling 8N1 serial receiver; 8E1 when UART_RX_PARITY_EN
//            is defined.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RsRx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  localparam int c_DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int c_DIV_W  = (c_DIV > 1) ? $clog2(c_DIV) : 1;
  localparam int c_SCNT_W = $clog2(OVERSAMPLE);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
  localparam logic [c_SCNT_W-1:0] c_SCNT_LAST = c_SCNT_W'(OVERSAMPLE - 1);
  localparam logic [c_SCNT_W-1:0] c_SCNT_MID  = c_SCNT_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    , S_PARITY  = 3'd5
`endif
  } state_t;

  logic               r_sync1, r_sync2;
  logic               w_line;
  logic [c_DIV_W-1:0] r_div;
  logic               w_tick;

  state_t              r_state, w_state_nxt;
  logic [c_SCNT_W-1:0] r_scnt, w_scnt_nxt;
  logic [2:0]          r_bidx, w_bidx_nxt;
  logic [7:0]          r_shreg, w_shreg_nxt;
  logic [7:0]          r_data, w_data_nxt;
  logic                r_valid, w_valid_nxt;
  logic                r_ferr, w_ferr_nxt;
  logic                w_bit_end;
  logic                w_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RsRx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_line = r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + c_DIV_W'(1);
  end

  assign w_tick    = (r_div == c_DIV_LAST);
  assign w_bit_end = (r_scnt == c_SCNT_LAST);

`ifdef UART_RX_PARITY_EN
  logic r_pmis, w_pmis_nxt;
  logic r_perr, w_perr_nxt;
  assign w_mis      = r_pmis;
  assign parity_err = r_perr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pmis <= 1'b0;
      r_perr <= 1'b0;
    end else begin
      r_pmis <= w_pmis_nxt;
      r_perr <= w_perr_nxt;
    end
  end
`else
  assign w_mis      = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_scnt  <= '0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      r_bidx  <= w_bidx_nxt;
      r_shreg <= w_shreg_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_bidx_nxt  = r_bidx;
    w_shreg_nxt = r_shreg;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_pmis_nxt  = r_pmis;
    w_perr_nxt  = 1'b0;
`endif
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          w_scnt_nxt = '0;
          if (!w_line) w_state_nxt = S_START;
        end
        S_START: begin
          // Re-check the line at mid start bit to reject glitches
          if (r_scnt == c_SCNT_MID) begin
            w_scnt_nxt  = '0;
            w_bidx_nxt  = '0;
            w_state_nxt = w_line ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            w_pmis_nxt  = 1'b0;
`endif
          end else begin
            w_scnt_nxt = r_scnt + c_SCNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            w_scnt_nxt  = '0;
            w_shreg_nxt = {w_line, r_shreg[7:1]};
            if (r_bidx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = S_PARITY;
`else
              w_state_nxt = S_STOP;
`endif
            end else begin
              w_bidx_nxt = r_bidx + 3'd1;
            end
          end else begin
            w_scnt_nxt = r_scnt + c_SCNT_W'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_bit_end) begin
            w_scnt_nxt  = '0;
            w_pmis_nxt  = w_line ^ (^r_shreg);
            w_state_nxt = S_STOP;
          end else begin
            w_scnt_nxt = r_scnt + c_SCNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_bit_end) begin
            w_scnt_nxt = '0;
            w_data_nxt = r_shreg;
`ifdef UART_RX_PARITY_EN
            w_perr_nxt = w_mis;
`endif
            if (w_line) begin
              w_valid_nxt = !w_mis;
              w_state_nxt = S_IDLE;
            end else begin
              w_ferr_nxt  = 1'b1;
              w_state_nxt = S_WAIT_HIGH;
            end
          end else begin
            w_scnt_nxt = r_scnt + c_SCNT_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (w_line) w_state_nxt = S_IDLE;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_scnt_nxt  = '0;
        end
      endcase
    end
  end

  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
//==============================================================================
// Module   : tb_uart_rx
// Brief    : Self-checking bench for uart_rx with a frame-level expectation queue.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_uart_rx;

  localparam int CLK_FREQ = 1600000;
  localparam int BAUD     = 25000;
  localparam int OS       = 16;
  localparam int BITCLK   = CLK_FREQ / BAUD;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Stop-bit centre relative to the falling edge of the start bit
  localparam int LAT    = (NBITS - 1) * BITCLK + BITCLK / 2;
  localparam int WIN_LO = LAT - 8;
  localparam int WIN_HI = LAT + 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RsRx;
  logic [7:0] data;
  logic       valid, frame_err, parity_err, busy;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .clk(clk), .rst(rst), .RsRx(RsRx), .data(data), .valid(valid),
    .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] d;
    logic [2:0] k;   // {parity_err, frame_err, valid}
    int         t0;
  } exp_t;

  exp_t       q[$];
  int         checks = 0, passed = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0;
  logic [7:0] model_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  logic [2:0] got;
  exp_t       e;
  always @(negedge clk) begin
    if (rst) begin
      model_data = 8'h00;
    end else begin
      got = {parity_err, frame_err, valid};
      if (got != 3'b000) begin
        if (valid)      n_valid++;
        if (frame_err)  n_ferr++;
        if (parity_err) n_perr++;
        if (q.size() == 0) begin
          check("unexpected_pulse", {29'd0, got}, 32'd0);
        end else begin
          e = q.pop_front();
          check("pulse_kind", {29'd0, got}, {29'd0, e.k});
          check("pulse_data", {24'd0, data}, {24'd0, e.d});
          check("pulse_latency_in_window",
                {31'd0, (cyc - e.t0 >= WIN_LO) && (cyc - e.t0 <= WIN_HI)}, 32'd1);
          model_data = e.d;
        end
      end else begin
        check("data_hold", {24'd0, data}, {24'd0, model_data});
        if (q.size() != 0 && (cyc - q[0].t0) > WIN_HI) begin
          check("pulse_timeout", cyc - q[0].t0, WIN_HI);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic drive_bit(input logic v);
    RsRx = v;
    repeat (BITCLK) @(posedge clk);
    #2;
  endtask

  task automatic idle(input int nbits);
    RsRx = 1'b1;
    repeat (nbits * BITCLK) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit pbad,
                            input int hold_low_bits);
    exp_t x;
    x.d  = b;
    x.t0 = cyc;
`ifdef UART_RX_PARITY_EN
    x.k = stop_ok ? (pbad ? 3'b100 : 3'b001) : (pbad ? 3'b110 : 3'b010);
`else
    x.k = stop_ok ? 3'b001 : 3'b010;
`endif
    q.push_back(x);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ pbad);
`endif
    drive_bit(stop_ok);
    for (int i = 0; i < hold_low_bits; i++) drive_bit(1'b0);
    RsRx = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
  endtask

  int nv, nf, np, exp_v;
  logic [7:0] rb;
  bit   rok, rpb;

  initial begin
    rst  = 1'b1;
    RsRx = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_valid", {31'd0, valid}, 0);
    check("reset_frame_err", {31'd0, frame_err}, 0);
    check("reset_parity_err", {31'd0, parity_err}, 0);
    check("reset_busy", {31'd0, busy}, 0);
    rst = 1'b0;
    idle(2);

    // Single frame
    nv = n_valid; nf = n_ferr;
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    idle(1); drain();
    check("single_data", {24'd0, data}, 32'h3C);
    check("single_valid_count", n_valid - nv, 1);
    check("single_no_ferr", n_ferr - nf, 0);

    // Reset in the middle of a frame
    RsRx = 1'b0;
    repeat (4 * BITCLK) @(posedge clk);
    #2;
    check("midframe_busy", {31'd0, busy}, 1);
    #1 rst = 1'b1;
    #1;
    check("midrst_data", {24'd0, data}, 32'h00);
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_valid", {31'd0, valid}, 0);
    check("midrst_frame_err", {31'd0, frame_err}, 0);
    check("midrst_parity_err", {31'd0, parity_err}, 0);
    RsRx = 1'b1;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    idle(2);
    send_frame(8'hA5, 1'b1, 1'b0, 0);
    idle(1); drain();
    check("after_reset_data", {24'd0, data}, 32'hA5);

    // Back-to-back frames, single stop bit
    nv = n_valid; nf = n_ferr;
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    idle(1); drain();
    check("b2b_valid_count", n_valid - nv, 3);
    check("b2b_last_data", {24'd0, data}, 32'h81);
    check("b2b_no_ferr", n_ferr - nf, 0);

    // Start-bit glitch of 4 ticks
    nv = n_valid;
    RsRx = 1'b0;
    repeat (4 * (BITCLK / OS)) @(posedge clk);
    #2;
    check("glitch_busy_during", {31'd0, busy}, 1);
    RsRx = 1'b1;
    idle(2);
    check("glitch_busy_after", {31'd0, busy}, 0);
    check("glitch_no_valid", n_valid - nv, 0);

    // Stop bit low, line held low two bit times
    nv = n_valid; nf = n_ferr;
    send_frame(8'h55, 1'b0, 1'b0, 2);
    idle(2); drain();
    check("ferr_data", {24'd0, data}, 32'h55);
    check("ferr_count", n_ferr - nf, 1);
    check("ferr_no_valid", n_valid - nv, 0);
    send_frame(8'h12, 1'b1, 1'b0, 0);
    idle(1); drain();
    check("post_ferr_data", {24'd0, data}, 32'h12);

`ifdef UART_RX_PARITY_EN
    nv = n_valid; np = n_perr;
    send_frame(8'h07, 1'b1, 1'b0, 0);
    idle(1); drain();
    check("par_good_valid", n_valid - nv, 1);
    send_frame(8'h07, 1'b1, 1'b1, 0);
    idle(1); drain();
    check("par_bad_perr", n_perr - np, 1);
    check("par_bad_no_valid", n_valid - nv, 1);
`endif

    // Randomized traffic
    nv = n_valid; exp_v = 0;
    for (int i = 0; i < 24; i++) begin
      rb  = 8'($urandom);
      rok = ($urandom_range(0, 7) != 0);
`ifdef UART_RX_PARITY_EN
      rpb = ($urandom_range(0, 3) == 0);
`else
      rpb = 1'b0;
`endif
      if (rok && !rpb) exp_v++;
      send_frame(rb, rok, rpb, rok ? 0 : $urandom_range(0, 2));
      idle(rok ? $urandom_range(0, 2) : $urandom_range(1, 2));
    end
    idle(1); drain();
    check("random_valid_count", n_valid - nv, exp_v);
    check("random_end_busy", {31'd0, busy}, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire
